// File: rtl/shift_rows_pipe.sv
// Pipelined Rijndael ShiftRows / InvShiftRows stage with a 2-entry output FIFO.
// The byte rotation is applied on the input side, so the buffer holds shifted data.
// out_state and out_tag read zero whenever the buffer is empty.
module shift_rows_pipe #(
   parameter int unsigned NB    = 4,
   parameter int unsigned TAG_W = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_inv,
   input  logic [32*NB-1:0]    in_state,
   input  logic [TAG_W-1:0]    in_tag,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [32*NB-1:0]    out_state,
   output logic [TAG_W-1:0]    out_tag
);

   localparam int unsigned W = 32 * NB;

   if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
      $error("shift_rows_pipe: NB must be 4, 6 or 8");
   end

   // Row rotation amount; the 256-bit block skips offset 2.
   function automatic int unsigned row_offset(input int unsigned r);
      if (NB == 8 && r >= 2) return r + 1;
      return r;
   endfunction

   logic [W-1:0]     shifted;
   logic [W-1:0]     mem_state [2];
   logic [TAG_W-1:0] mem_tag   [2];
   logic             wr_ptr_q, rd_ptr_q;
   logic [1:0]       count_q, count_d;
   logic             ready_en_q;
   logic             push, pop;

   // Byte permutation; s(r,c) sits at state[W-1-8*(4c+r) -: 8].
   always_comb begin
      shifted = '0;
      for (int unsigned c = 0; c < NB; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            int unsigned src;
            src = in_inv ? (c + NB - row_offset(r)) % NB : (c + row_offset(r)) % NB;
            shifted[W-1-8*(4*c+r) -: 8] = in_state[W-1-8*(4*src+r) -: 8];
         end
      end
   end

   // in_ready depends only on registered state, never on out_ready.
   assign in_ready  = ready_en_q && (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Next occupancy from push/pop.
   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Holds in_ready low until the first edge after reset is released.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ready_en_q <= 1'b0;
      else          ready_en_q <= 1'b1;
   end

   // Occupancy and pointers; flush overrides any concurrent push or pop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q  <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
      end else if (flush) begin
         count_q  <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
      end else begin
         count_q <= count_d;
         if (push) wr_ptr_q <= ~wr_ptr_q;
         if (pop)  rd_ptr_q <= ~rd_ptr_q;
      end
   end

   // Storage for shifted blocks and their tags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 2; i++) begin
            mem_state[i] <= '0;
            mem_tag[i]   <= '0;
         end
      end else if (push && !flush) begin
         mem_state[wr_ptr_q] <= shifted;
         mem_tag[wr_ptr_q]   <= in_tag;
      end
   end

   // Head of the buffer, masked so stale entries never leak out.
   always_comb begin
      out_state = '0;
      out_tag   = '0;
      if (out_valid) begin
         out_state = mem_state[rd_ptr_q];
         out_tag   = mem_tag[rd_ptr_q];
      end
   end

endmodule
